mcu_pixel_ingest: RTL and testbench
===================================

MCU_PIXEL_INGEST -- requirements
Module: mcu_pixel_ingest

Interface
REQ-001 Parameter MEMORY_DEPTH, default 4096, number of 12-bit pixel words; SHALL be a power of two.
REQ-002 Parameter DIV, default 3, divide ratio of the divided-clock output; legal range 2..255.
REQ-003 system_clock  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mcu_bus_clock  input  1  asynchronous MCU strobe; a byte is valid on its rising edge.
REQ-006 mcu_bus  input  8  MCU byte; held stable at least 4 system_clock cycles after the mcu_bus_clock rising edge.
REQ-007 mcu_bus_command_data  input  1  1 = command byte, 0 = pixel data byte; same timing as mcu_bus.
REQ-008 mcu_command_clock  output  1  one-cycle pulse per accepted command byte.
REQ-009 command_byte  output  8  last accepted command byte.
REQ-010 mcu_pixel_clock  output  1  one-cycle pulse per assembled pixel.
REQ-011 pixel_data  output  12  last assembled pixel, RGB444 {R,G,B}.
REQ-012 framebuffer_read_pointer  input  22  read address.
REQ-013 read_data  output  12  pixel word at the registered read address.
REQ-014 divided_clock  output  1  system_clock divided by DIV (see Configuration).

Function
REQ-015 mcu_bus_clock SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected when the previous synchronized sample is 0 and the current one is 1.
REQ-016 On a detected edge, mcu_bus and mcu_bus_command_data SHALL be sampled in the same cycle; the resulting pulse SHALL assert 3 cycles after the pin edge and last exactly one cycle.
REQ-017 Command byte: command_byte SHALL be updated, mcu_command_clock SHALL pulse, and the byte phase SHALL be cleared to 0.
REQ-018 Command 0x01 SHALL additionally reset the write pointer to 0; all other commands (including 0x02, VGA start) SHALL only pulse.
REQ-019 Data byte, phase 0: the byte SHALL be stored as {R[3:0],G[3:0]} = byte[7:4],byte[3:0], and phase SHALL become 1; no pulse.
REQ-020 Data byte, phase 1: B = byte[3:0], byte[7:4] ignored; pixel_data SHALL be set to {R,G,B}, mcu_pixel_clock SHALL pulse, and phase SHALL return to 0.
REQ-021 On each mcu_pixel_clock pulse, pixel_data SHALL be written to memory[write_pointer] and the pointer incremented, wrapping from MEMORY_DEPTH-1 to 0.
REQ-022 Read: the read address SHALL be framebuffer_read_pointer modulo MEMORY_DEPTH (low bits only); read_data SHALL be valid 1 cycle after the address is presented.
REQ-023 A write and a read to the same address in the same cycle SHALL return the old contents (read-before-write).
REQ-024 Memory contents after power-up are undefined and SHALL NOT be cleared by reset.

Reset
REQ-025 Reset SHALL clear: synchronizer flops to 0, edge-history flop to 1 (no spurious edge if mcu_bus_clock is high at release), phase to 0, write pointer to 0, mcu_command_clock and mcu_pixel_clock to 0, command_byte to 0x00, pixel_data to 0x000, read_data to 0x000, and the divider counter and divided_clock to 0.
REQ-026 Reset asserted mid-pixel SHALL discard the partial byte; the first data byte after reset SHALL be phase 0.

Configuration
REQ-027 Macro CLOCK_DIVIDER_EN: when defined, divided_clock SHALL toggle every DIV system_clock cycles (period 2*DIV cycles); when undefined, divided_clock SHALL be constant 0 and no divider logic SHALL be present.

Verification
REQ-028 Data bytes 0xA5 then 0x0C -> one mcu_pixel_clock pulse, pixel_data=0xA5C, written to address 0, read back as 0xA5C one cycle after read pointer 0.
REQ-029 Command 0x02 -> mcu_command_clock pulse 3 cycles after the edge, command_byte=0x02, write pointer unchanged.
REQ-030 Data 0x12, command 0x01, data 0x34, 0x56 -> first byte discarded, pixel 0x346 written to address 0.
REQ-031 Write MEMORY_DEPTH+1 pixels -> the last pixel overwrites address 0; read pointer MEMORY_DEPTH+3 reads address 3.
REQ-032 Hold mcu_bus_clock high through reset release -> no pulse until a subsequent low-to-high edge.
REQ-033 With CLOCK_DIVIDER_EN and DIV=3 -> divided_clock period 6 cycles after reset; without the macro it stays 0.

Source files
------------

// File: rtl/mcu_pixel_ingest_if.sv
// mcu_pixel_ingest_if
//   Bundles the MCU byte bus, the command/pixel strobes and the frame-buffer
//   read port of mcu_pixel_ingest.
//   master : MCU / display side (drives the bus and the read pointer).
//   slave  : mcu_pixel_ingest (produces strobes, pixels and read data).
//
//   mcu_bus_clock            asynchronous strobe, byte valid on its rising edge
//   mcu_bus[7:0]             MCU byte
//   mcu_bus_command_data     1 = command byte, 0 = pixel data byte
//   mcu_command_clock        one-cycle pulse per accepted command byte
//   command_byte[7:0]        last accepted command byte
//   mcu_pixel_clock          one-cycle pulse per assembled pixel
//   pixel_data[11:0]         last assembled pixel, RGB444 {R,G,B}
//   framebuffer_read_pointer read address (low bits used)
//   read_data[11:0]          pixel word at the registered read address
//   divided_clock            divided system clock (0 unless CLOCK_DIVIDER_EN)
interface mcu_pixel_ingest_if;
    logic        mcu_bus_clock;
    logic [7:0]  mcu_bus;
    logic        mcu_bus_command_data;
    logic        mcu_command_clock;
    logic [7:0]  command_byte;
    logic        mcu_pixel_clock;
    logic [11:0] pixel_data;
    logic [21:0] framebuffer_read_pointer;
    logic [11:0] read_data;
    logic        divided_clock;

    modport master (
        output mcu_bus_clock, mcu_bus, mcu_bus_command_data, framebuffer_read_pointer,
        input  mcu_command_clock, command_byte, mcu_pixel_clock, pixel_data,
               read_data, divided_clock
    );

    modport slave (
        input  mcu_bus_clock, mcu_bus, mcu_bus_command_data, framebuffer_read_pointer,
        output mcu_command_clock, command_byte, mcu_pixel_clock, pixel_data,
               read_data, divided_clock
    );
endinterface

// File: rtl/mcu_pixel_ingest.sv
// mcu_pixel_ingest
//   Receives bytes from an asynchronous MCU parallel bus, separates command
//   bytes from pixel data, assembles RGB444 pixels from byte pairs and stores
//   them in a wrapping frame buffer with a registered read port.
//
//   Ports:
//     system_clock  sole clock, rising edge
//     reset         synchronous, active-high
//     bus           mcu_pixel_ingest_if.slave (MCU byte bus, strobes,
//                   pixel/command outputs, frame-buffer read port,
//                   divided_clock)
//
//   Parameters:
//     MEMORY_DEPTH  frame-buffer depth in 12-bit words, power of two
//     DIV           divide ratio of divided_clock, 2..255
//
//   Optional feature macro: CLOCK_DIVIDER_EN
//     defined   -> divided_clock toggles every DIV cycles (period 2*DIV)
//     undefined -> divided_clock is tied to 0, no divider hardware
module mcu_pixel_ingest #(
    parameter int MEMORY_DEPTH = 4096,
    parameter int DIV          = 3
) (
    input  logic              system_clock,
    input  logic              reset,
    mcu_pixel_ingest_if.slave bus
);
    localparam int AW = $clog2(MEMORY_DEPTH);

    if ((MEMORY_DEPTH < 2) || ((MEMORY_DEPTH & (MEMORY_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("MEMORY_DEPTH must be a power of two");
    end
    if ((DIV < 2) || (DIV > 255)) begin : g_bad_div
        $error("DIV must be in 2..255");
    end

    typedef enum logic { PH_RG = 1'b0, PH_B = 1'b1 } phase_t;

    logic          sync_p0, sync_p1, hist_p2;
    logic          vld_p0, vld_p1;
    logic          edge_det;
    phase_t        phase_q, phase_d;
    logic          cmd_take, rg_take, pix_take;
    logic          cmd_pulse_p3, pix_pulse_p3;
    logic [7:0]    cmd_q;
    logic [7:0]    rg_q;
    logic [11:0]   pix_q;
    logic [AW-1:0] wp;
    logic [AW-1:0] rd_addr;
    logic [11:0]   rd_q;
    logic [11:0]   mem [MEMORY_DEPTH];
    logic          unused_ptr_bits;

    // Stage p0/p1: two-flop synchronizer; p2: edge history.
    // vld_pN marks synchronizer flops that hold a real pin sample. Until both
    // do, the history is held at 1, so a pin that is already high when reset
    // releases is never seen as a rising edge.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b1;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            sync_p0 <= bus.mcu_bus_clock;
            sync_p1 <= sync_p0;
            hist_p2 <= vld_p1 ? sync_p1 : 1'b1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
        end
    end

    assign edge_det = sync_p1 & ~hist_p2;

    // Byte-phase FSM: state register
    always_ff @(posedge system_clock) begin
        if (reset) phase_q <= PH_RG;
        else       phase_q <= phase_d;
    end

    // Byte-phase FSM: next state and per-byte actions
    always_comb begin
        phase_d  = phase_q;
        cmd_take = 1'b0;
        rg_take  = 1'b0;
        pix_take = 1'b0;
        if (edge_det) begin
            if (bus.mcu_bus_command_data) begin
                cmd_take = 1'b1;
                phase_d  = PH_RG;
            end else begin
                case (phase_q)
                    PH_RG: begin
                        rg_take = 1'b1;
                        phase_d = PH_B;
                    end
                    PH_B: begin
                        pix_take = 1'b1;
                        phase_d  = PH_RG;
                    end
                    default: phase_d = PH_RG;
                endcase
            end
        end
    end

    // Stage p3: registered strobes, command byte, pixel and write pointer
    always_ff @(posedge system_clock) begin
        if (reset) begin
            cmd_pulse_p3 <= 1'b0;
            pix_pulse_p3 <= 1'b0;
            cmd_q        <= 8'h00;
            pix_q        <= 12'h000;
            wp           <= '0;
        end else begin
            cmd_pulse_p3 <= cmd_take;
            pix_pulse_p3 <= pix_take;
            if (cmd_take)
                cmd_q <= bus.mcu_bus;
            if (pix_take)
                pix_q <= {rg_q, bus.mcu_bus[3:0]};
            if (cmd_take && (bus.mcu_bus == 8'h01))
                wp <= '0;
            else if (pix_pulse_p3)
                wp <= wp + AW'(1);
        end
    end

    // First half of a pixel; a stale value is harmless because the phase
    // FSM decides whether it is ever combined with a blue byte.
    always_ff @(posedge system_clock) begin
        if (rg_take)
            rg_q <= bus.mcu_bus;
    end

    // Frame buffer: written in the pixel-strobe cycle, never cleared.
    always_ff @(posedge system_clock) begin
        if (pix_pulse_p3 && !reset)
            mem[wp] <= pix_q;
    end

    // Registered read; a same-cycle write to this address returns old data.
    assign rd_addr         = bus.framebuffer_read_pointer[AW-1:0];
    assign unused_ptr_bits = ^bus.framebuffer_read_pointer[21:AW];

    always_ff @(posedge system_clock) begin
        if (reset) rd_q <= 12'h000;
        else       rd_q <= mem[rd_addr];
    end

`ifdef CLOCK_DIVIDER_EN
    logic [7:0] div_cnt;
    logic       div_q;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            div_cnt <= 8'd0;
            div_q   <= 1'b0;
        end else if (div_cnt == 8'(DIV - 1)) begin
            div_cnt <= 8'd0;
            div_q   <= ~div_q;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign bus.divided_clock = div_q;
`else
    assign bus.divided_clock = 1'b0;
`endif

    assign bus.mcu_command_clock = cmd_pulse_p3;
    assign bus.command_byte      = cmd_q;
    assign bus.mcu_pixel_clock   = pix_pulse_p3;
    assign bus.pixel_data        = pix_q;
    assign bus.read_data         = rd_q;
endmodule

// File: tb/tb_mcu_pixel_ingest.sv
// tb_mcu_pixel_ingest
//   Drives MCU byte transactions (directed and $urandom) into
//   mcu_pixel_ingest and compares strobes, command byte, pixel, frame-buffer
//   reads and divided_clock against a behavioural model of the byte protocol.
module tb_mcu_pixel_ingest;
    localparam int DEPTH  = 16;
    localparam int TB_DIV = 3;

    logic system_clock = 1'b0;
    logic reset        = 1'b1;

    always #5 system_clock = ~system_clock;

    mcu_pixel_ingest_if mcu ();

    mcu_pixel_ingest #(
        .MEMORY_DEPTH(DEPTH),
        .DIV         (TB_DIV)
    ) dut (
        .system_clock(system_clock),
        .reset       (reset),
        .bus         (mcu)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the byte protocol
    int          m_phase;
    int          m_wp;
    logic [7:0]  m_rg;
    logic [7:0]  m_cmd;
    logic [11:0] m_pix;
    logic [11:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];

    logic [11:0] tb_rs [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_wp    = 0;
        m_cmd   = 8'h00;
        m_pix   = 12'h000;
    endtask

    // One MCU byte: strobe rises just after a clock edge, stays high for
    // five cycles, then the bus is left idle long enough to resynchronise.
    task automatic send_byte(input bit cmd, input logic [7:0] b);
        logic [7:0] cm;
        logic [7:0] pm;
        bit         exp_pix;
        exp_pix = !cmd && (m_phase == 1);
        cm = 8'h00;
        pm = 8'h00;
        @(posedge system_clock); #1;
        mcu.mcu_bus              = b;
        mcu.mcu_bus_command_data = cmd;
        mcu.mcu_bus_clock        = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge system_clock); #1;
            cm[i]    = mcu.mcu_command_clock;
            pm[i]    = mcu.mcu_pixel_clock;
            tb_rs[i] = mcu.read_data;
            if (i == 4) mcu.mcu_bus_clock = 1'b0;
        end
        if (cmd) begin
            m_cmd   = b;
            m_phase = 0;
            if (b == 8'h01) m_wp = 0;
        end else if (m_phase == 0) begin
            m_rg    = b;
            m_phase = 1;
        end else begin
            m_pix         = {m_rg, b[3:0]};
            m_mem[m_wp]   = m_pix;
            m_vld[m_wp]   = 1'b1;
            m_wp          = (m_wp + 1) % DEPTH;
            m_phase       = 0;
        end
        // A strobe is one cycle wide, visible on the third edge after the pin.
        chk("cmd_pulse", 32'(cm), cmd ? 32'h04 : 32'h00);
        chk("pix_pulse", 32'(pm), exp_pix ? 32'h04 : 32'h00);
        chk("command_byte", 32'(mcu.command_byte), 32'(m_cmd));
        chk("pixel_data", 32'(mcu.pixel_data), 32'(m_pix));
    endtask

    task automatic read_chk(input logic [21:0] ptr);
        int a;
        a = int'(ptr) % DEPTH;
        @(posedge system_clock); #1;
        mcu.framebuffer_read_pointer = ptr;
        @(posedge system_clock); #1;
        if (m_vld[a]) chk("read_data", 32'(mcu.read_data), 32'(m_mem[a]));
    endtask

    task automatic do_reset(input bit hold);
        int pulses;
        logic exp_div;
        @(posedge system_clock); #1;
        reset             = 1'b1;
        mcu.mcu_bus_clock = hold;
        repeat (2) @(posedge system_clock);
        #1;
        chk("rst_cmd_clk", 32'(mcu.mcu_command_clock), 32'h0);
        chk("rst_pix_clk", 32'(mcu.mcu_pixel_clock), 32'h0);
        chk("rst_command_byte", 32'(mcu.command_byte), 32'h0);
        chk("rst_pixel_data", 32'(mcu.pixel_data), 32'h0);
        chk("rst_read_data", 32'(mcu.read_data), 32'h0);
        chk("rst_divided_clock", 32'(mcu.divided_clock), 32'h0);
        reset = 1'b0;
        model_reset();
        pulses = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge system_clock); #1;
`ifdef CLOCK_DIVIDER_EN
            exp_div = ((n / TB_DIV) % 2) == 1;
`else
            exp_div = 1'b0;
`endif
            chk("divided_clock", 32'(mcu.divided_clock), 32'(exp_div));
            pulses += int'(mcu.mcu_command_clock) + int'(mcu.mcu_pixel_clock);
        end
        chk("no_pulse_after_reset", 32'(pulses), 32'h0);
        if (hold) begin
            mcu.mcu_bus_clock = 1'b0;
            repeat (3) @(posedge system_clock);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          c;
        logic [7:0]  b;
        logic [11:0] old;
        mcu.mcu_bus_clock            = 1'b0;
        mcu.mcu_bus                  = 8'h00;
        mcu.mcu_bus_command_data     = 1'b0;
        mcu.framebuffer_read_pointer = 22'd0;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        model_reset();
        m_rg = 8'h00;

        do_reset(1'b0);

        // Basic pixel A5,0C -> 0xA5C at address 0
        send_byte(1'b0, 8'hA5);
        send_byte(1'b0, 8'h0C);
        read_chk(22'd0);

        // Command 0x02 only pulses; next pixel lands at address 1
        send_byte(1'b1, 8'h02);
        send_byte(1'b0, 8'h11);
        send_byte(1'b0, 8'h22);
        read_chk(22'd1);

        // Half pixel discarded by command 0x01, pointer rewinds
        send_byte(1'b0, 8'h12);
        send_byte(1'b1, 8'h01);
        send_byte(1'b0, 8'h34);
        send_byte(1'b0, 8'h56);
        read_chk(22'd0);
        read_chk(22'h3FFFF0);

        // Random byte stream
        for (int i = 0; i < 60; i++) begin
            c = ($urandom_range(0, 4) == 0);
            b = 8'($urandom);
            if (c && ($urandom_range(0, 2) == 0)) b = 8'h01;
            send_byte(c, b);
        end
        for (int i = 0; i < 20; i++) read_chk(22'($urandom));

        // DEPTH+1 pixels: wrap to address 0, read-before-write on collision
        send_byte(1'b1, 8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(1'b0, 8'($urandom));
            send_byte(1'b0, 8'($urandom));
        end
        old = m_mem[0];
        send_byte(1'b0, 8'($urandom));
        mcu.framebuffer_read_pointer = 22'd0;
        send_byte(1'b0, 8'($urandom));
        chk("rbw_old", 32'(tb_rs[3]), 32'(old));
        chk("rbw_new", 32'(tb_rs[4]), 32'(m_mem[0]));
        read_chk(22'(DEPTH + 3));

        // Reset mid-pixel discards the half byte
        send_byte(1'b0, 8'h7F);
        do_reset(1'b0);
        send_byte(1'b0, 8'h9A);
        send_byte(1'b0, 8'hBC);
        read_chk(22'd0);

        // Strobe held high through reset release, then a real edge
        do_reset(1'b1);
        send_byte(1'b1, 8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
